// File: rtl/sigmoid_lut_arbiter.sv
// Round-robin front end for one shared sigmoid ROM: picks a neuron, maps its signed
// pre-activation to an offset-binary ROM address and routes the 2-clk-later data back.

module sigmoid_addr_map #(
   parameter int IN_WIDTH   = 16,
   parameter int ADDR_WIDTH = 12
)(
   input  logic [IN_WIDTH-1:0]   x,
   output logic [ADDR_WIDTH-1:0] addr
);
   localparam logic [IN_WIDTH-1:0] MAXV =
      {{(IN_WIDTH-ADDR_WIDTH+1){1'b0}}, {(ADDR_WIDTH-1){1'b1}}};
   localparam logic [IN_WIDTH-1:0] MINV = ~MAXV;

   logic hi, lo;

   assign hi = $signed(x) > $signed(MAXV);
   assign lo = $signed(x) < $signed(MINV);

   // Saturate, then flip the sign bit to land in offset binary.
   always_comb begin
      if (hi)      addr = '1;
      else if (lo) addr = '0;
      else         addr = {~x[ADDR_WIDTH-1], x[ADDR_WIDTH-2:0]};
   end
endmodule

module sigmoid_lut_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int IN_WIDTH   = 16,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*IN_WIDTH-1:0]  req_x,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [ADDR_WIDTH-1:0]        rom_addr,
   input  logic [DATA_WIDTH-1:0]        rom_data,
   output logic [NUM_REQ-1:0]           resp_valid,
   output logic [DATA_WIDTH-1:0]        resp_data,
   output logic                         busy
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0][IN_WIDTH-1:0]   x_arr;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] lane_addr;
   logic [IDW-1:0]                     rr_ptr, gnt_id, idx, s1_id, s2_id;
   logic                               gnt_found, accept;
   logic [2:1]                         vld_pipe;

   assign x_arr = req_x;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      sigmoid_addr_map #(
         .IN_WIDTH   (IN_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_map (
         .x    (x_arr[g]),
         .addr (lane_addr[g])
      );
   end

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      req_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = idx;
         end
      end
      req_ready[gnt_id] = gnt_found;
   end

   assign accept = gnt_found;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         rom_addr <= '0;
         vld_pipe <= '0;
         s1_id    <= '0;
         s2_id    <= '0;
      end else begin
         vld_pipe <= {vld_pipe[1], accept};
         s2_id    <= s1_id;
         // Address and id only move on accept so the ROM input stays quiet when idle.
         if (accept) begin
            rom_addr <= lane_addr[gnt_id];
            s1_id    <= gnt_id;
            rr_ptr   <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
         end
      end
   end

   always_comb begin
      resp_valid        = '0;
      resp_valid[s2_id] = vld_pipe[2];
   end

   assign resp_data = rom_data;
   assign busy      = |vld_pipe;
endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// Directed bench for sigmoid_lut_arbiter with a registered-output ROM model.
module tb_sigmoid_lut_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0][15:0] xs;
   logic [63:0] req_x;
   logic [3:0]  req_ready;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic [3:0]  resp_valid;
   logic [7:0]  resp_data;
   logic        busy;

   int checks = 0;
   int failures = 0;

   assign req_x = xs;

   sigmoid_lut_arbiter #(.NUM_REQ(4), .IN_WIDTH(16), .ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
      .rom_addr(rom_addr), .rom_data(rom_data), .resp_valid(resp_valid),
      .resp_data(resp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_f(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]};
   endfunction

   always_ff @(posedge clk) rom_data <= rom_f(rom_addr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]       vld;
      logic [3:0][15:0] x;
      logic [3:0]       rdy;
      logic [11:0]      addr;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic [3:0] v, input int x0, input int x1, input int x2,
                               input int x3, input logic [3:0] r, input int a);
      vec_t t;
      t.vld  = v;
      t.x    = {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
      t.rdy  = r;
      t.addr = 12'(a);
      return t;
   endfunction

   initial begin
      logic [3:0]  prev_rdy;
      logic [11:0] prev_addr, last_addr;
      int wait_cnt, rr_m;
      logic [3:0] g, exp_g;

      // rows: valid, x0..x3, expected ready, expected rom_addr (held value when no accept)
      tv.push_back(mk(4'b0100,      0,    0,     0,    0, 4'b0100, 2048));
      tv.push_back(mk(4'b0001, -30000,    0,     0,    0, 4'b0001,    0));
      tv.push_back(mk(4'b0001,  30000,    0,     0,    0, 4'b0001, 4095));
      tv.push_back(mk(4'b0010,      0,-2048,     0,    0, 4'b0010,    0));
      tv.push_back(mk(4'b1000,      0,    0,     0, 2047, 4'b1000, 4095));
      tv.push_back(mk(4'b0000,      5,    5,     5,    5, 4'b0000, 4095));
      tv.push_back(mk(4'b1010,      0,   -1,     0,   -1, 4'b0010, 2047));
      tv.push_back(mk(4'b1000,      0,    0,     0,   -1, 4'b1000, 2047));
      for (int r = 0; r < 2; r++) begin
         tv.push_back(mk(4'b1111, -2049, 1000, -1000, 2048, 4'b0001,    0));
         tv.push_back(mk(4'b1111, -2049, 1000, -1000, 2048, 4'b0010, 3048));
         tv.push_back(mk(4'b1111, -2049, 1000, -1000, 2048, 4'b0100, 1048));
         tv.push_back(mk(4'b1111, -2049, 1000, -1000, 2048, 4'b1000, 4095));
      end
      tv.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 4095));
      tv.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 4095));

      rst = 1'b1;
      req_valid = '0;
      xs = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_addr", 32'(rom_addr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_resp", 32'(resp_valid), 0);
      req_valid = 4'b0100;
      #1;
      chk("rst_ready", 32'(req_ready), 32'b0100);
      req_valid = '0;
      rst = 1'b0;

      // table: one row per clock, responses checked two edges after each accept
      prev_rdy = '0;
      prev_addr = '0;
      last_addr = '0;
      @(posedge clk); #1;
      foreach (tv[i]) begin
         req_valid = tv[i].vld;
         xs = tv[i].x;
         #1;
         chk($sformatf("ready[%0d]", i), 32'(req_ready), 32'(tv[i].rdy));
         @(posedge clk); #1;
         if (tv[i].rdy != 0) last_addr = tv[i].addr;
         chk($sformatf("addr[%0d]", i), 32'(rom_addr), 32'(last_addr));
         chk($sformatf("resp_v[%0d]", i), 32'(resp_valid), 32'(prev_rdy));
         if (prev_rdy != 0)
            chk($sformatf("resp_d[%0d]", i), 32'(resp_data), 32'(rom_f(prev_addr)));
         chk($sformatf("busy[%0d]", i), 32'(busy), 32'((tv[i].rdy != 0) || (prev_rdy != 0)));
         prev_rdy = tv[i].rdy;
         prev_addr = tv[i].addr;
      end

      // fairness: req1 always valid, req3 raised every third cycle and held until granted
      req_valid = '0;
      xs = '0;
      rr_m = 0;
      wait_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         req_valid[1] = 1'b1;
         if (!req_valid[3] && (c % 3 == 0)) req_valid[3] = 1'b1;
         #1;
         g = req_ready;
         if (req_valid[3] && (rr_m == 2 || rr_m == 3)) exp_g = 4'b1000;
         else exp_g = 4'b0010;
         chk($sformatf("fair_gnt[%0d]", c), 32'(g), 32'(exp_g));
         if (req_valid[3] && g[1]) wait_cnt++;
         if (g[3]) wait_cnt = 0;
         chk($sformatf("fair_wait[%0d]", c), 32'(wait_cnt > 1), 0);
         rr_m = g[3] ? 0 : 2;
         @(posedge clk); #1;
         if (g[3]) req_valid[3] = 1'b0;
      end
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1;

      // async reset with two lookups in flight
      req_valid = 4'b0001;
      xs[0] = 16'd300;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_valid = '0;
      chk("pre_rst_busy", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_resp", 32'(resp_valid), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_addr", 32'(rom_addr), 0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst_resp[%0d]", c), 32'(resp_valid), 0);
         chk($sformatf("post_rst_busy[%0d]", c), 32'(busy), 0);
      end

      // single requester 2 with x=0 straight after reset
      req_valid = 4'b0100;
      xs = '0;
      #1;
      chk("t1_ready", 32'(req_ready), 32'b0100);
      @(posedge clk); #1;
      req_valid = '0;
      chk("t1_addr", 32'(rom_addr), 2048);
      chk("t1_busy1", 32'(busy), 1);
      @(posedge clk); #1;
      chk("t1_resp_v", 32'(resp_valid), 32'b0100);
      chk("t1_resp_d", 32'(resp_data), 32'(rom_f(12'd2048)));
      @(posedge clk); #1;
      chk("t1_resp_end", 32'(resp_valid), 0);
      chk("t1_busy0", 32'(busy), 0);

      // idle gap between two accepts; rr_ptr is 3 so requester 0 wins first
      req_valid = 4'b0001;
      xs[0] = 16'd500;
      #1;
      chk("gap_ready0", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      req_valid = '0;
      chk("gap_addr0", 32'(rom_addr), 2548);
      @(posedge clk); #1;
      chk("gap_resp_v0", 32'(resp_valid), 32'b0001);
      chk("gap_resp_d0", 32'(resp_data), 32'(rom_f(12'd2548)));
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk($sformatf("gap_hold[%0d]", c), 32'(rom_addr), 2548);
         chk($sformatf("gap_quiet[%0d]", c), 32'(resp_valid), 0);
      end
      req_valid = 4'b0110;
      xs[1] = -16'sd500;
      xs[2] = 16'd7;
      #1;
      chk("gap_ready1", 32'(req_ready), 32'b0010);
      @(posedge clk); #1;
      req_valid = 4'b0100;
      chk("gap_addr1", 32'(rom_addr), 1548);
      chk("gap_resp_none", 32'(resp_valid), 0);
      @(posedge clk); #1;
      req_valid = '0;
      chk("gap_addr2", 32'(rom_addr), 2055);
      chk("gap_resp_v1", 32'(resp_valid), 32'b0010);
      chk("gap_resp_d1", 32'(resp_data), 32'(rom_f(12'd1548)));
      @(posedge clk); #1;
      chk("gap_resp_v2", 32'(resp_valid), 32'b0100);
      chk("gap_resp_d2", 32'(resp_data), 32'(rom_f(12'd2055)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
